core_mem: RTL and testbench
===========================

Name: core_mem

Overview:
- Memory stage of the 5-stage RV64IM pipeline, directly upstream of the write-back stage. Consumes EX/MEM fields and performs loads and stores over a req/gnt/rvalid data-memory bus.
- Aligns and sign- or zero-extends load data.
- Its registered outputs form the MEM/WB register: mem_data_o, alu_o, imm_o, pc_o and mem2reg_o feed write-back directly.

Parameters:
- XLEN, 64, operand, address and data width (equals OPERAND_WIDTH).
- RFIDX_W, 5, register-file index width (equals CPU_RFIDX_WIDTH).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- valid_i  in  1  EX/MEM holds a valid instruction
- ready_o  out  1  stage can accept; equals (state==IDLE)
- flush_i  in  1  kill the in-flight or incoming instruction
- pc_i/instr_i/imm_i  in  64/32/64  passthrough fields
- rsd_idx_i  in  5  destination register
- alu_i  in  64  ALU result; effective address for memory ops
- rs2_i  in  64  store data
- mem_read_i, mem_write_i  in  1,1  load or store (mutually exclusive)
- funct3_i  in  3  size and sign
- mem2reg_i  in  3  write-back select, passed through
- valid_o  out  1  MEM/WB entry valid (single-cycle pulse per instruction)
- pc_o/instr_o/imm_o/alu_o  out  64/32/64/64  registered passthrough
- rsd_idx_o  out  5  destination; forced to 0 on misalign
- mem_data_o  out  64  extended load data; 0 for non-loads
- mem2reg_o  out  3  passthrough
- misalign_o  out  1  misaligned access flag, qualified by valid_o
- dmem_req_o, dmem_we_o  out  1,1  bus request, write enable
- dmem_addr_o  out  64  {alu[63:3],3'b0}
- dmem_wdata_o  out  64  store data shifted into its byte lane
- dmem_wstrb_o  out  8  byte strobes
- dmem_gnt_i, dmem_rvalid_i  in  1,1  grant, read data valid
- dmem_rdata_i  in  64  read data

Behaviour:
- Reset: all outputs, including registered fields, are 0. State=IDLE. ready_o=1 follows from state.
- States:
  - IDLE: waiting for an instruction.
  - REQ: dmem_req_o=1 and bus fields held stable until dmem_gnt_i.
  - WAIT: load granted, waiting for dmem_rvalid_i.
- Accept: valid_i && ready_o && !flush_i. Latch all fields.
- Non-memory instruction: next cycle valid_o=1 with fields passed through. Stays IDLE. Latency 1.
- Memory op, aligned: go to REQ.
- Memory op, misaligned: no bus request. Next cycle valid_o=1, misalign_o=1, rsd_idx_o=0. Stays IDLE.
- Alignment rules:
  - H: addr[0]==0.
  - W: addr[1:0]==0.
  - D: addr[2:0]==0.
  - B: always aligned.
- REQ on gnt:
  - Store: next cycle valid_o=1, go to IDLE.
  - Load: go to WAIT.
  - gnt in the request cycle itself is legal.
- WAIT on rvalid: mem_data_o takes the extended data and valid_o=1 next cycle; go to IDLE. rvalid is never sampled in the same cycle as gnt.
- Store lanes, with off=addr[2:0]:
  - wstrb: SB 0x01<<off, SH 0x03<<off, SW 0x0F<<off, SD 0xFF.
  - wdata = rs2 << (8*off).
- Load extract: (rdata >> 8*off), then by funct3:
  - LB/LH/LW sign-extend from bit 7/15/31.
  - LBU/LHU/LWU zero-extend.
  - LD takes the full word.
  - Store funct3 codes 000/001/010/011 are SB/SH/SW/SD.
- Flush:
  - IDLE: the incoming instruction is dropped.
  - REQ before gnt: request is deasserted next cycle, go to IDLE, no valid_o.
  - REQ with gnt in the same cycle: the store has already committed to memory, so valid_o is still suppressed.
  - WAIT: stay until rvalid, discard data, no valid_o. ready_o remains 0 until then.
- Simultaneous: while ready_o=0 the upstream holds its instruction; valid_i is ignored.
- Reset mid-transaction: state returns to IDLE immediately and any pending rvalid is ignored. The bus side must tolerate an abandoned request.

Decomposition:
- defines.v holds:
  - existing width macros;
  - LSU funct3 encodings (LB..LWU, SB..SD);
  - state encodings IDLE=2'd0, REQ=2'd1, WAIT=2'd2.
- Sub-module core_mem_align is purely combinational. It handles:
  - misalign detect;
  - wstrb/wdata generation;
  - load extract and extension.
- The FSM and MEM/WB registers stay in core_mem.

Test Plan:
1. ALU op: alu_i=0x1234, rsd_idx_i=5, mem2reg_i=000 -> next cycle valid_o=1, alu_o=0x1234, rsd_idx_o=5, no dmem_req_o.
2. SH: alu_i=0x1006, rs2_i=0xBEEF, gnt held low 2 cycles -> dmem_addr_o=0x1000, wstrb=0xC0, wdata=0xBEEF<<48, req stable for 3 cycles; valid_o the cycle after gnt.
3. LB and LBU: alu_i=0x2003, rdata=0x00000000_80000000 -> LB gives mem_data_o=0xFFFFFFFFFFFFFF80; LBU gives 0x80. valid_o the cycle after rvalid.
4. LW misaligned at 0x3002 -> no req; valid_o=1, misalign_o=1, rsd_idx_o=0.
5. LD at 0x4000, flush_i in WAIT, rvalid 3 cycles later -> no valid_o; ready_o low until the cycle after rvalid.
6. Assert rst_n=0 while in REQ -> dmem_req_o=0, valid_o=0, ready_o=1 immediately; a subsequent ALU op completes normally.

Source files
------------

// File: rtl/core_mem_pkg.sv
// core_mem_pkg
// Shared widths, LSU funct3 encodings, memory-stage FSM state encoding and
// the access-alignment helper used by the memory stage of the RV64IM pipeline.
package core_mem_pkg;

    localparam int XLEN_DFLT    = 64;
    localparam int RFIDX_W_DFLT = 5;

    // Load encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // Store encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } mem_state_e;

    // Access size lives in funct3[1:0] for both loads and stores.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
        logic bad;
        case (size)
            2'b01:   bad = off[0];
            2'b10:   bad = |off[1:0];
            2'b11:   bad = |off[2:0];
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/core_mem_if.sv
// core_mem_if
// Data-memory bus between the memory stage and the data memory.
//   req/we/addr/wdata/wstrb : master -> slave, held stable until gnt
//   gnt                     : slave accepts the request this cycle
//   rvalid/rdata            : read data return, never in the gnt cycle
interface core_mem_if #(
    parameter int XLEN = 64
) ();
    logic              req;
    logic              we;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
    logic [XLEN/8-1:0] wstrb;
    logic              gnt;
    logic              rvalid;
    logic [XLEN-1:0]   rdata;

    modport master (
        output req, we, addr, wdata, wstrb,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, wstrb,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/core_mem_align.sv
// core_mem_align
// Purely combinational byte-lane logic for the memory stage.
//   st_off_i/st_size_i/st_data_i : incoming access offset, size, store data
//   misalign_o                   : access crosses its natural alignment
//   wstrb_o/wdata_o              : store strobes and lane-shifted data
//   ld_off_i/ld_funct3_i/rdata_i : latched offset, load type, raw read data
//   ld_data_o                    : aligned, sign/zero-extended load data
module core_mem_align
    import core_mem_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      st_off_i,
    input  logic [1:0]      st_size_i,
    input  logic [XLEN-1:0] st_data_i,
    output logic            misalign_o,
    output logic [7:0]      wstrb_o,
    output logic [XLEN-1:0] wdata_o,
    input  logic [2:0]      ld_off_i,
    input  logic [2:0]      ld_funct3_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [XLEN-1:0] ld_data_o
);

    logic [XLEN-1:0] ld_shift;

    assign misalign_o = is_misaligned(st_size_i, st_off_i);
    assign wdata_o    = st_data_i << {st_off_i, 3'b000};
    assign ld_shift   = rdata_i >> {ld_off_i, 3'b000};

    always_comb begin
        wstrb_o = 8'h00;
        case (st_size_i)
            2'b00:   wstrb_o = 8'h01 << st_off_i;
            2'b01:   wstrb_o = 8'h03 << st_off_i;
            2'b10:   wstrb_o = 8'h0F << st_off_i;
            default: wstrb_o = 8'hFF;
        endcase
    end

    always_comb begin
        ld_data_o = ld_shift;
        case (ld_funct3_i)
            F3_LB:   ld_data_o = {{(XLEN-8){ld_shift[7]}},   ld_shift[7:0]};
            F3_LH:   ld_data_o = {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
            F3_LW:   ld_data_o = {{(XLEN-32){ld_shift[31]}}, ld_shift[31:0]};
            F3_LBU:  ld_data_o = {{(XLEN-8){1'b0}},  ld_shift[7:0]};
            F3_LHU:  ld_data_o = {{(XLEN-16){1'b0}}, ld_shift[15:0]};
            F3_LWU:  ld_data_o = {{(XLEN-32){1'b0}}, ld_shift[31:0]};
            default: ld_data_o = ld_shift;
        endcase
    end

endmodule

// File: rtl/core_mem.sv
// core_mem
// Memory stage of the RV64IM pipeline; its registered outputs are the MEM/WB
// register. Loads/stores go over the req/gnt/rvalid bus on the dmem port.
//   valid_i/ready_o/flush_i        : EX/MEM handshake and kill
//   pc/instr/imm/alu/rs2/rsd_idx   : EX/MEM fields (alu is the address)
//   mem_read/mem_write/funct3      : access type, size and sign
//   mem2reg                        : write-back select, passed through
//   valid_o ... misalign_o         : MEM/WB entry, valid_o pulses once
//   dmem                           : data-memory bus master
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | ready for a new instruction; ALU ops and misaligned ops retire
// S_REQ  | bus request held stable until gnt
// S_WAIT | load granted, waiting for rvalid (kill_q drops the result)
module core_mem
    import core_mem_pkg::*;
#(
    parameter int XLEN    = XLEN_DFLT,
    parameter int RFIDX_W = RFIDX_W_DFLT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic               flush_i,
    input  logic [XLEN-1:0]    pc_i,
    input  logic [31:0]        instr_i,
    input  logic [XLEN-1:0]    imm_i,
    input  logic [RFIDX_W-1:0] rsd_idx_i,
    input  logic [XLEN-1:0]    alu_i,
    input  logic [XLEN-1:0]    rs2_i,
    input  logic               mem_read_i,
    input  logic               mem_write_i,
    input  logic [2:0]         funct3_i,
    input  logic [2:0]         mem2reg_i,
    output logic               valid_o,
    output logic [XLEN-1:0]    pc_o,
    output logic [31:0]        instr_o,
    output logic [XLEN-1:0]    imm_o,
    output logic [XLEN-1:0]    alu_o,
    output logic [RFIDX_W-1:0] rsd_idx_o,
    output logic [XLEN-1:0]    mem_data_o,
    output logic [2:0]         mem2reg_o,
    output logic               misalign_o,
    core_mem_if.master         dmem
);

    mem_state_e         state_q;
    logic               valid_q;
    logic               misalign_q;
    logic [XLEN-1:0]    pc_q;
    logic [31:0]        instr_q;
    logic [XLEN-1:0]    imm_q;
    logic [XLEN-1:0]    alu_q;
    logic [RFIDX_W-1:0] rsd_q;
    logic [XLEN-1:0]    mem_data_q;
    logic [2:0]         mem2reg_q;
    logic [2:0]         funct3_q;
    logic               is_load_q;
    logic               kill_q;
    logic               req_q;
    logic               we_q;
    logic [XLEN-1:0]    addr_q;
    logic [XLEN-1:0]    wdata_q;
    logic [7:0]         wstrb_q;

    logic               accept;
    logic               mem_op;
    logic               st_misalign;
    logic [7:0]         st_wstrb;
    logic [XLEN-1:0]    st_wdata;
    logic [XLEN-1:0]    ld_data;

    assign accept = valid_i && (state_q == S_IDLE) && !flush_i;
    assign mem_op = mem_read_i || mem_write_i;

    core_mem_align #(.XLEN(XLEN)) u_align (
        .st_off_i    (alu_i[2:0]),
        .st_size_i   (funct3_i[1:0]),
        .st_data_i   (rs2_i),
        .misalign_o  (st_misalign),
        .wstrb_o     (st_wstrb),
        .wdata_o     (st_wdata),
        .ld_off_i    (alu_q[2:0]),
        .ld_funct3_i (funct3_q),
        .rdata_i     (dmem.rdata),
        .ld_data_o   (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
            pc_q       <= '0;
            instr_q    <= '0;
            imm_q      <= '0;
            alu_q      <= '0;
            rsd_q      <= '0;
            mem_data_q <= '0;
            mem2reg_q  <= '0;
            funct3_q   <= '0;
            is_load_q  <= 1'b0;
            kill_q     <= 1'b0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        pc_q       <= pc_i;
                        instr_q    <= instr_i;
                        imm_q      <= imm_i;
                        alu_q      <= alu_i;
                        mem2reg_q  <= mem2reg_i;
                        funct3_q   <= funct3_i;
                        is_load_q  <= mem_read_i;
                        mem_data_q <= '0;
                        kill_q     <= 1'b0;
                        we_q       <= mem_write_i;
                        addr_q     <= {alu_i[XLEN-1:3], 3'b000};
                        wdata_q    <= st_wdata;
                        wstrb_q    <= mem_write_i ? st_wstrb : 8'h00;
                        if (mem_op && !st_misalign) begin
                            state_q    <= S_REQ;
                            req_q      <= 1'b1;
                            misalign_q <= 1'b0;
                            rsd_q      <= rsd_idx_i;
                        end else begin
                            valid_q    <= 1'b1;
                            misalign_q <= mem_op;
                            rsd_q      <= mem_op ? '0 : rsd_idx_i;
                        end
                    end
                end
                S_REQ: begin
                    if (dmem.gnt) begin
                        req_q <= 1'b0;
                        if (is_load_q) begin
                            // A granted load must still drain its rvalid.
                            state_q <= S_WAIT;
                            kill_q  <= flush_i;
                        end else begin
                            state_q <= S_IDLE;
                            valid_q <= !flush_i;
                        end
                    end else if (flush_i) begin
                        req_q   <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (flush_i) begin
                        kill_q <= 1'b1;
                    end
                    if (dmem.rvalid) begin
                        state_q <= S_IDLE;
                        if (!kill_q && !flush_i) begin
                            valid_q    <= 1'b1;
                            mem_data_q <= ld_data;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o    = (state_q == S_IDLE);
    assign valid_o    = valid_q;
    assign pc_o       = pc_q;
    assign instr_o    = instr_q;
    assign imm_o      = imm_q;
    assign alu_o      = alu_q;
    assign rsd_idx_o  = rsd_q;
    assign mem_data_o = mem_data_q;
    assign mem2reg_o  = mem2reg_q;
    assign misalign_o = misalign_q;

    assign dmem.req   = req_q;
    assign dmem.we    = we_q;
    assign dmem.addr  = addr_q;
    assign dmem.wdata = wdata_q;
    assign dmem.wstrb = wstrb_q;

endmodule

// File: tb/tb_core_mem.sv
// tb_core_mem
// Directed-vector bench for the memory stage. Inputs change and outputs are
// sampled on the falling edge; the data-memory slave is driven by hand.
module tb_core_mem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i, flush_i, mem_read_i, mem_write_i;
    logic [63:0] pc_i, imm_i, alu_i, rs2_i;
    logic [31:0] instr_i;
    logic [4:0]  rsd_idx_i;
    logic [2:0]  funct3_i, mem2reg_i;
    logic        ready_o, valid_o, misalign_o;
    logic [63:0] pc_o, imm_o, alu_o, mem_data_o;
    logic [31:0] instr_o;
    logic [4:0]  rsd_idx_o;
    logic [2:0]  mem2reg_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    core_mem_if #(.XLEN(64)) dmem ();

    core_mem #(.XLEN(64), .RFIDX_W(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .flush_i     (flush_i),
        .pc_i        (pc_i),
        .instr_i     (instr_i),
        .imm_i       (imm_i),
        .rsd_idx_i   (rsd_idx_i),
        .alu_i       (alu_i),
        .rs2_i       (rs2_i),
        .mem_read_i  (mem_read_i),
        .mem_write_i (mem_write_i),
        .funct3_i    (funct3_i),
        .mem2reg_i   (mem2reg_i),
        .valid_o     (valid_o),
        .pc_o        (pc_o),
        .instr_o     (instr_o),
        .imm_o       (imm_o),
        .alu_o       (alu_o),
        .rsd_idx_o   (rsd_idx_o),
        .mem_data_o  (mem_data_o),
        .mem2reg_o   (mem2reg_o),
        .misalign_o  (misalign_o),
        .dmem        (dmem.master)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drop_inputs();
        valid_i     = 1'b0;
        mem_read_i  = 1'b0;
        mem_write_i = 1'b0;
        flush_i     = 1'b0;
    endtask

    // Presents one instruction; caller is at a falling edge.
    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [63:0] alu, input logic [63:0] rs2,
                         input logic [4:0] idx);
        valid_i     = 1'b1;
        mem_read_i  = rd;
        mem_write_i = wr;
        funct3_i    = f3;
        alu_i       = alu;
        rs2_i       = rs2;
        rsd_idx_i   = idx;
        pc_i        = 64'h8000_0000 + alu;
        instr_i     = 32'h0000_0013;
        imm_i       = 64'h10;
        mem2reg_i   = rd ? 3'b001 : 3'b000;
    endtask

    // Aligned load with immediate grant and rvalid the following cycle.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                           input logic [63:0] rdata, input logic [63:0] exp);
        @(negedge clk);
        issue(1'b1, 1'b0, f3, addr, 64'h0, 5'd9);
        @(negedge clk);
        drop_inputs();
        chk({tag, "_req"}, {63'h0, dmem.req}, 64'h1);
        dmem.gnt = 1'b1;
        @(negedge clk);
        dmem.gnt    = 1'b0;
        chk({tag, "_wait_novalid"}, {63'h0, valid_o}, 64'h0);
        dmem.rvalid = 1'b1;
        dmem.rdata  = rdata;
        @(negedge clk);
        dmem.rvalid = 1'b0;
        chk({tag, "_valid"}, {63'h0, valid_o}, 64'h1);
        chk({tag, "_data"}, mem_data_o, exp);
    endtask

    initial begin
        rst_n       = 1'b0;
        drop_inputs();
        funct3_i    = '0;
        alu_i       = '0;
        rs2_i       = '0;
        rsd_idx_i   = '0;
        pc_i        = '0;
        instr_i     = '0;
        imm_i       = '0;
        mem2reg_i   = '0;
        dmem.gnt    = 1'b0;
        dmem.rvalid = 1'b0;
        dmem.rdata  = '0;

        repeat (2) @(negedge clk);
        chk("rst_valid", {63'h0, valid_o}, 64'h0);
        chk("rst_ready", {63'h0, ready_o}, 64'h1);
        chk("rst_req", {63'h0, dmem.req}, 64'h0);
        chk("rst_alu", alu_o, 64'h0);
        chk("rst_memdata", mem_data_o, 64'h0);
        rst_n = 1'b1;

        // ALU op, single-cycle latency
        @(negedge clk);
        issue(1'b0, 1'b0, 3'b000, 64'h1234, 64'h0, 5'd5);
        @(negedge clk);
        drop_inputs();
        chk("alu_valid", {63'h0, valid_o}, 64'h1);
        chk("alu_alu", alu_o, 64'h1234);
        chk("alu_rsd", {59'h0, rsd_idx_o}, 64'd5);
        chk("alu_noreq", {63'h0, dmem.req}, 64'h0);
        chk("alu_memdata", mem_data_o, 64'h0);
        @(negedge clk);
        chk("alu_pulse", {63'h0, valid_o}, 64'h0);

        // SH at 0x1006 with gnt held off for two cycles
        issue(1'b0, 1'b1, 3'b001, 64'h1006, 64'hBEEF, 5'd0);
        @(negedge clk);
        drop_inputs();
        chk("sh_req1", {63'h0, dmem.req}, 64'h1);
        chk("sh_addr", dmem.addr, 64'h1000);
        chk("sh_wstrb", {56'h0, dmem.wstrb}, 64'hC0);
        chk("sh_wdata", dmem.wdata, 64'hBEEF_0000_0000_0000);
        chk("sh_we", {63'h0, dmem.we}, 64'h1);
        chk("sh_ready", {63'h0, ready_o}, 64'h0);
        @(negedge clk);
        chk("sh_req2", {63'h0, dmem.req}, 64'h1);
        chk("sh_addr2", dmem.addr, 64'h1000);
        @(negedge clk);
        chk("sh_req3", {63'h0, dmem.req}, 64'h1);
        chk("sh_novalid", {63'h0, valid_o}, 64'h0);
        dmem.gnt = 1'b1;
        @(negedge clk);
        dmem.gnt = 1'b0;
        chk("sh_valid", {63'h0, valid_o}, 64'h1);
        chk("sh_req_drop", {63'h0, dmem.req}, 64'h0);
        chk("sh_ready_back", {63'h0, ready_o}, 64'h1);

        // SD at 0x6000, grant in the request cycle
        @(negedge clk);
        issue(1'b0, 1'b1, 3'b011, 64'h6000, 64'h1122_3344_5566_7788, 5'd0);
        @(negedge clk);
        drop_inputs();
        chk("sd_wstrb", {56'h0, dmem.wstrb}, 64'hFF);
        chk("sd_wdata", dmem.wdata, 64'h1122_3344_5566_7788);
        dmem.gnt = 1'b1;
        @(negedge clk);
        dmem.gnt = 1'b0;
        chk("sd_valid", {63'h0, valid_o}, 64'h1);

        // Load extraction vectors
        do_load("lb",  3'b000, 64'h2003, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
        do_load("lbu", 3'b100, 64'h2003, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080);
        do_load("lw",  3'b010, 64'h2004, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321);
        do_load("lwu", 3'b110, 64'h2004, 64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321);
        do_load("lh",  3'b001, 64'h2002, 64'h0000_0000_F00D_0000, 64'hFFFF_FFFF_FFFF_F00D);
        do_load("ld",  3'b011, 64'h2008, 64'hCAFE_F00D_1234_5678, 64'hCAFE_F00D_1234_5678);

        // LW misaligned
        @(negedge clk);
        issue(1'b1, 1'b0, 3'b010, 64'h3002, 64'h0, 5'd7);
        @(negedge clk);
        drop_inputs();
        chk("mis_valid", {63'h0, valid_o}, 64'h1);
        chk("mis_flag", {63'h0, misalign_o}, 64'h1);
        chk("mis_rsd", {59'h0, rsd_idx_o}, 64'd0);
        chk("mis_noreq", {63'h0, dmem.req}, 64'h0);
        chk("mis_ready", {63'h0, ready_o}, 64'h1);

        // Flush in IDLE drops the incoming instruction
        @(negedge clk);
        issue(1'b0, 1'b0, 3'b000, 64'h55, 64'h0, 5'd3);
        flush_i = 1'b1;
        @(negedge clk);
        drop_inputs();
        chk("flush_idle_novalid", {63'h0, valid_o}, 64'h0);

        // LD flushed in WAIT, rvalid three cycles later
        @(negedge clk);
        issue(1'b1, 1'b0, 3'b011, 64'h4000, 64'h0, 5'd4);
        @(negedge clk);
        drop_inputs();
        dmem.gnt = 1'b1;
        @(negedge clk);
        dmem.gnt = 1'b0;
        flush_i  = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        chk("fl_ready1", {63'h0, ready_o}, 64'h0);
        @(negedge clk);
        chk("fl_ready2", {63'h0, ready_o}, 64'h0);
        @(negedge clk);
        chk("fl_ready3", {63'h0, ready_o}, 64'h0);
        chk("fl_novalid_wait", {63'h0, valid_o}, 64'h0);
        dmem.rvalid = 1'b1;
        dmem.rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
        @(negedge clk);
        dmem.rvalid = 1'b0;
        chk("fl_novalid", {63'h0, valid_o}, 64'h0);
        chk("fl_ready_back", {63'h0, ready_o}, 64'h1);
        chk("fl_memdata", mem_data_o, 64'h0);

        // Reset while in REQ
        @(negedge clk);
        issue(1'b0, 1'b1, 3'b010, 64'h5000, 64'h77, 5'd0);
        @(negedge clk);
        drop_inputs();
        chk("rr_req_before", {63'h0, dmem.req}, 64'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("rr_req", {63'h0, dmem.req}, 64'h0);
        chk("rr_valid", {63'h0, valid_o}, 64'h0);
        chk("rr_ready", {63'h0, ready_o}, 64'h1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(1'b0, 1'b0, 3'b000, 64'hABCD, 64'h0, 5'd11);
        @(negedge clk);
        drop_inputs();
        chk("rr_alu_valid", {63'h0, valid_o}, 64'h1);
        chk("rr_alu_alu", alu_o, 64'hABCD);
        chk("rr_alu_rsd", {59'h0, rsd_idx_o}, 64'd11);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
